// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte buffer behind uart_rx with a sticky overflow flag
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow,
    input  logic                         clear_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic [WIDTH-1:0] r_out_data, w_out_next;
    logic             r_out_valid, r_overflow;
    logic             w_full, w_push, w_pop, w_drop;
    always_comb begin
        w_full       = r_count == CW'(DEPTH);
        w_pop        = r_out_valid && out_ready;
        w_push       = in_valid && (!w_full || w_pop);
        w_drop       = in_valid && !w_push;
        w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_next = (w_push && !w_pop) ? r_count + CW'(1) :
                       (w_pop && !w_push) ? r_count - CW'(1) : r_count;
        // the slot about to be shown may be the one written this cycle
        w_out_next   = (w_push && r_wr_ptr == w_rd_next) ? in_data : r_mem[w_rd_next];
    end
    always_ff @(posedge clk)
        if (rst_n && w_push)
            r_mem[r_wr_ptr] <= in_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wr_ptr    <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_out_valid <= w_count_next != '0;
            r_out_data  <= w_out_next;
            r_overflow  <= w_drop ? 1'b1 : clear_overflow ? 1'b0 : r_overflow;
        end
    end
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-model scoreboard plus directed checks for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clear_overflow = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q [$];
    logic       m_ovf = 1'b0;
    logic       armed = 1'b0;
    int         max_cnt;
    int         sent;
    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .overflow(overflow), .clear_overflow(clear_overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // outputs at each negedge reflect the last posedge; the model then steps to the next one
    always @(negedge clk) begin
        int  sz;
        logic m_pop, m_push;
        sz = q.size();
        if (armed) begin
            chk("count", 32'(count), 32'(sz));
            chk("out_valid", 32'(out_valid), 32'(sz != 0));
            chk("full", 32'(full), 32'(sz == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (sz != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        end
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop  = sz != 0 && out_ready;
            m_push = in_valid && (sz < DEPTH || m_pop);
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(in_data);
            m_ovf = (in_valid && !m_push) ? 1'b1 : clear_overflow ? 1'b0 : m_ovf;
        end
        armed = 1'b1;
    end
    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask
    task automatic drain(input int n);
        out_ready = 1'b1;
        tick(n);
        out_ready = 1'b0;
    endtask
    initial begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick(100);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick(2);
        in_valid = 1'b1;
        in_data  = 8'hD5;
        tick();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hD5);
        chk("single_count", 32'(count), 32'd1);
        drain(1);
        chk("single_empty", 32'(out_valid), 32'd0);
        chk("single_cnt0", 32'(count), 32'd0);
        fill(DEPTH, 8'h00);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_head", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        tick();
        chk("pop_unfull", 32'(full), 32'd0);
        tick(DEPTH - 1);
        out_ready = 1'b0;
        chk("drained", 32'(out_valid), 32'd0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
        fill(DEPTH, 8'h20);
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);
        drain(DEPTH);
        in_valid       = 1'b1;
        in_data        = 8'h77;
        clear_overflow = 1'b1;
        fill(DEPTH, 8'h40);
        in_valid       = 1'b1;
        tick();
        in_valid       = 1'b0;
        clear_overflow = 1'b0;
        chk("set_wins", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        drain(DEPTH);
        clear_overflow = 1'b0;
        max_cnt = 0;
        sent    = 0;
        for (int c = 0; c < 420; c++) begin
            in_valid  = (c % 10 == 0) && sent < 40;
            in_data   = 8'(sent + 8'h80);
            sent     += int'(in_valid);
            out_ready = (c % 3 == 0);
            tick();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("strm_sent", 32'(sent), 32'd40);
        chk("strm_max_le2", 32'(max_cnt <= 2), 32'd1);
        chk("strm_ovf", 32'(overflow), 32'd0);
        for (int c = 0; c < 600; c++) begin
            in_valid       = $urandom_range(0, 2) != 0;
            in_data        = 8'($urandom);
            out_ready      = $urandom_range(0, 2) == 0;
            clear_overflow = $urandom_range(0, 15) == 0;
            tick();
        end
        in_valid       = 1'b0;
        clear_overflow = 1'b0;
        drain(DEPTH + 2);
        chk("final_empty", 32'(out_valid), 32'd0);
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
